// File: rtl/wb_master_if_pkg.sv
// Shared types and helpers for the CPU-side Wishbone initiator.
package wb_master_if_pkg;

  localparam int unsigned WbDataW   = 32;
  localparam int unsigned WbAddrW   = 32;
  localparam int unsigned WbSelW    = 16;
  localparam int unsigned SlaveIdxW = 3;
  localparam int unsigned TimerW    = 8;

  // Encodings are kept stable so waveforms line up with the interconnect docs.
  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StBusy      = 2'b01,
    StWaitStall = 2'b11
  } wb_state_e;

  // One-hot slave select from the decoded address field.
  function automatic logic [WbSelW-1:0] slave_select(input logic [SlaveIdxW-1:0] idx);
    return WbSelW'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_master_if.sv
// CPU-side Wishbone initiator: turns a single-cycle pipeline request into a bus cycle,
// stalls the pipeline until ack, and aborts on flush or after a bounded wait.
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int unsigned STALL_IDX = 1,
  parameter int unsigned DEC_LSB   = 29,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [WbAddrW-1:0]  cpu_addr_i,
  input  logic [WbDataW-1:0]  cpu_data_i,
  output logic [WbDataW-1:0]  cpu_data_o,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                err_o,
  output logic [WbAddrW-1:0]  wb_addr_o,
  output logic [WbDataW-1:0]  wb_data_o,
  output logic                wb_we_o,
  output logic [WbSelW-1:0]   wb_select_o,
  input  logic [WbDataW-1:0]  wb_data_i,
  input  logic                wb_ack_i
);

  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  wb_state_e           state_q, state_d;
  logic [WbAddrW-1:0]  addr_q, addr_d;
  logic [WbDataW-1:0]  wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [WbSelW-1:0]   sel_q, sel_d;
  logic [WbDataW-1:0]  rd_buf_q, rd_buf_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                err_q, err_d;

  logic                pipe_stalled;
  logic                timeout;
  logic [SlaveIdxW-1:0] slave_idx;

  // Only one bit of the stall vector belongs to this port.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall_i;

  assign pipe_stalled = stall_i[STALL_IDX];
  assign slave_idx    = cpu_addr_i[DEC_LSB+2:DEC_LSB];
  assign timeout      = (state_q == StBusy) && (timer_q == TimerLast);

  // Next-state and registered-output computation for the bus FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    rd_buf_d = rd_buf_q;
    timer_d  = timer_q;
    err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = slave_select(slave_idx);
          timer_d = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        if (flush_i) begin
          // A write may already have landed at the slave; nothing to undo.
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = StIdle;
        end else if (wb_ack_i) begin
          sel_d    = '0;
          we_d     = 1'b0;
          rd_buf_d = wb_data_i;
          state_d  = pipe_stalled ? StWaitStall : StIdle;
        end else if (timeout) begin
          sel_d    = '0;
          we_d     = 1'b0;
          rd_buf_d = '0;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StWaitStall: begin
        // Hold the read data until the pipeline can consume it.
        if (flush_i || !pipe_stalled) begin
          state_d = StIdle;
        end
      end

      default: begin
        sel_d   = '0;
        we_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State and bus-side registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      rd_buf_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      rd_buf_q <= rd_buf_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // Pipeline-facing combinational outputs.
  always_comb begin
    stall_req_o = 1'b0;
    cpu_data_o  = '0;
    unique case (state_q)
      StIdle: begin
        stall_req_o = cpu_ce_i && !flush_i;
      end
      StBusy: begin
        stall_req_o = !wb_ack_i && !flush_i && !timeout;
        if (wb_ack_i) begin
          cpu_data_o = wb_data_i;
        end
      end
      StWaitStall: begin
        cpu_data_o = rd_buf_q;
      end
      default: begin
        stall_req_o = 1'b0;
        cpu_data_o  = '0;
      end
    endcase
  end

  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_we_o     = we_q;
  assign wb_select_o = sel_q;
  assign err_o       = err_q;

endmodule
